fjmem_core: RTL and testbench

FJMEM_CORE -- requirements
Module: fjmem_core

---
 rtl/fjmem_pkg.sv | 22 ++
 rtl/fjmem_sync.sv | 21 ++
 rtl/fjmem_core.sv | 156 +++++++++++++++
 tb/tb_fjmem_core.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fjmem_pkg.sv
// Shared definitions for the JTAG-to-flash bridge: command codes, FSM states
// and default bus widths.
package fjmem_pkg;

  localparam int ADDR_W_DEF  = 24;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_READ   = 2'b01,
    CMD_WRITE  = 2'b10,
    CMD_DETECT = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/fjmem_sync.sv
// Two-flop synchronizer bringing one asynchronous JTAG level into sys_clk.
module fjmem_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fjmem_core.sv
// JTAG user-DR to flash bus bridge: a scan chain carries cmd/addr/data and an
// Update-DR launches one flash access whose result is loaded back for readout.
//
// state  | meaning
// IDLE   | waiting for an update edge to latch a command
// ACCESS | flash_stb high, waiting for flash_ack or timeout
// DONE   | one cycle: load status and result into the scan register
module fjmem_core import fjmem_pkg::*; #(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                TIMEOUT   = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] DETECT_ID = DATA_W'(16'h0001)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              jtag_tck,
  input  logic              jtag_rst,
  input  logic              jtag_update,
  input  logic              jtag_shift,
  input  logic              jtag_tdi,
  output logic              jtag_tdo,
  output logic              flash_stb,
  output logic              flash_we,
  output logic [ADDR_W-1:0] flash_adr,
  output logic [DATA_W-1:0] flash_dat_w,
  input  logic [DATA_W-1:0] flash_dat_r,
  input  logic              flash_ack
);

  localparam int SR_W  = 2 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic tck_s, rst_s, upd_s, shift_s, tdi_s;
  logic tck_d, upd_d;
  logic tck_rise, upd_rise;

  fjmem_sync u_sync_tck (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(jtag_tck),    .q(tck_s));
  fjmem_sync u_sync_rst (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(jtag_rst),    .q(rst_s));
  fjmem_sync u_sync_upd (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(jtag_update), .q(upd_s));
  fjmem_sync u_sync_shf (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(jtag_shift),  .q(shift_s));
  fjmem_sync u_sync_tdi (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .d(jtag_tdi),    .q(tdi_s));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tck_d <= 1'b0;
      upd_d <= 1'b0;
    end else begin
      tck_d <= tck_s;
      upd_d <= upd_s;
    end
  end

  assign tck_rise = tck_s & ~tck_d;
  assign upd_rise = upd_s & ~upd_d;

  logic [SR_W-1:0]   sr;
  state_e            state, state_nxt;
  cmd_e              cmd_q, sr_cmd;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              err;
  logic              latch, bus_start, timeout, done_load;

  assign sr_cmd   = cmd_e'(sr[1:0]);
  assign jtag_tdo = sr[0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    bus_start = 1'b0;
    timeout   = 1'b0;
    done_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (upd_rise && sr_cmd != CMD_NOP) begin
          latch = 1'b1;
          if (sr_cmd == CMD_DETECT) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ACCESS;
            bus_start = 1'b1;
          end
        end
      end
      ACCESS: begin
        // ack wins over a timeout landing in the same cycle
        if (flash_ack) begin
          state_nxt = DONE;
        end else if (int'(wait_cnt) + 1 >= TIMEOUT) begin
          state_nxt = DONE;
          timeout   = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        done_load = ~rst_s;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_q       <= CMD_NOP;
      flash_stb   <= 1'b0;
      flash_we    <= 1'b0;
      flash_adr   <= '0;
      flash_dat_w <= '0;
      rdata_q     <= '0;
      wait_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      if (latch) begin
        cmd_q       <= sr_cmd;
        flash_we    <= (sr_cmd == CMD_WRITE);
        flash_adr   <= sr[ADDR_W+1:2];
        flash_dat_w <= sr[SR_W-1:ADDR_W+2];
      end
      if (bus_start) begin
        flash_stb <= 1'b1;
        wait_cnt  <= '0;
      end else if (state == ACCESS) begin
        if (wait_cnt != {CNT_W{1'b1}}) wait_cnt <= wait_cnt + CNT_W'(1);
        if (flash_ack) begin
          flash_stb <= 1'b0;
          rdata_q   <= flash_dat_r;
        end else if (timeout) begin
          flash_stb <= 1'b0;
          err       <= 1'b1;
        end
      end
      if (state == DONE) err <= 1'b0;
    end
  end

  // The DONE load beats a coinciding shift edge; a TAP reset beats both.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sr <= '0;
    end else if (rst_s) begin
      sr <= '0;
    end else if (done_load) begin
      sr[1:0] <= {err, 1'b1};
      if (cmd_q == CMD_READ)        sr[SR_W-1:ADDR_W+2] <= rdata_q;
      else if (cmd_q == CMD_DETECT) sr[SR_W-1:ADDR_W+2] <= DETECT_ID;
    end else if (tck_rise && shift_s) begin
      sr <= {tdi_s, sr[SR_W-1:1]};
    end
  end

endmodule

// File: tb/tb_fjmem_core.sv
// Directed bench for fjmem_core: scans commands in over JTAG, models the flash
// slave, and scoreboards bus requests and scan readbacks.
module tb_fjmem_core;
  import fjmem_pkg::*;

  localparam int AW   = 24;
  localparam int DW   = 16;
  localparam int SR_W = 2 + AW + DW;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          jtag_tck = 1'b0, jtag_rst = 1'b0, jtag_update = 1'b0;
  logic          jtag_shift = 1'b0, jtag_tdi = 1'b0;
  logic          jtag_tdo;
  logic          flash_stb, flash_we;
  logic [AW-1:0] flash_adr;
  logic [DW-1:0] flash_dat_w;
  logic [DW-1:0] flash_dat_r = '0;
  logic          flash_ack = 1'b0;

  fjmem_core #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255), .DETECT_ID(16'h0001)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .jtag_tck(jtag_tck), .jtag_rst(jtag_rst), .jtag_update(jtag_update),
    .jtag_shift(jtag_shift), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .flash_stb(flash_stb), .flash_we(flash_we), .flash_adr(flash_adr),
    .flash_dat_w(flash_dat_w), .flash_dat_r(flash_dat_r), .flash_ack(flash_ack)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } bus_t;

  typedef struct {
    logic [SR_W-1:0] val;
    logic [SR_W-1:0] mask;
  } scan_t;

  bus_t  exp_bus[$];
  scan_t exp_scan[$];

  int n_pass = 0, n_total = 0;
  int bus_starts = 0, stb_cycles = 0;
  int ack_delay = 3;
  bit ack_en = 1'b1;
  logic [DW-1:0] rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Flash slave model: acks after ack_delay cycles of flash_stb, checks each request.
  initial begin
    bit busy = 1'b0;
    int wait_c = 0;
    bus_t e;
    forever begin
      @(negedge sys_clk);
      flash_ack = 1'b0;
      if (flash_stb) begin
        if (!busy) begin
          busy = 1'b1;
          wait_c = 0;
          bus_starts++;
          check("bus_expected", 64'(exp_bus.size() > 0), 64'd1);
          if (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            check("bus_req", {23'd0, flash_we, flash_adr, flash_dat_w}, {23'd0, e.we, e.adr, e.dat});
          end
        end else begin
          wait_c++;
        end
        stb_cycles++;
        if (ack_en && wait_c == ack_delay) begin
          flash_ack = 1'b1;
          flash_dat_r = rdata;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  task automatic scan(input logic [SR_W-1:0] din, output logic [SR_W-1:0] dout);
    jtag_shift = 1'b1;
    wait_clk(4);
    for (int i = 0; i < SR_W; i++) begin
      dout[i] = jtag_tdo;
      jtag_tdi = din[i];
      wait_clk(4);
      jtag_tck = 1'b1;
      wait_clk(4);
      jtag_tck = 1'b0;
    end
    wait_clk(4);
    jtag_shift = 1'b0;
    wait_clk(4);
  endtask

  task automatic pulse_update();
    jtag_update = 1'b1;
    wait_clk(4);
    jtag_update = 1'b0;
    wait_clk(4);
  endtask

  task automatic push_scan(input logic [SR_W-1:0] val, input logic [SR_W-1:0] mask);
    scan_t s;
    s.val = val;
    s.mask = mask;
    exp_scan.push_back(s);
  endtask

  task automatic push_bus(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    bus_t b;
    b.we = we;
    b.adr = adr;
    b.dat = dat;
    exp_bus.push_back(b);
  endtask

  task automatic readback(input string tag);
    logic [SR_W-1:0] o;
    scan_t e;
    scan('0, o);
    check({tag, "_queued"}, 64'(exp_scan.size() > 0), 64'd1);
    if (exp_scan.size() > 0) begin
      e = exp_scan.pop_front();
      check(tag, 64'(o & e.mask), 64'(e.val & e.mask));
    end
  endtask

  function automatic logic [SR_W-1:0] vec(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [1:0] c);
    return {d, a, c};
  endfunction

  initial begin
    logic [SR_W-1:0] dummy;
    logic [SR_W-1:0] all1;
    logic [SR_W-1:0] no_data;
    int starts0;
    all1 = '1;
    no_data = {{DW{1'b0}}, {(AW+2){1'b1}}};

    wait_clk(3);
    check("rst_tdo", 64'(jtag_tdo), 64'd0);
    check("rst_stb", 64'(flash_stb), 64'd0);
    check("rst_we", 64'(flash_we), 64'd0);
    check("rst_adr", 64'(flash_adr), 64'd0);
    check("rst_datw", 64'(flash_dat_w), 64'd0);
    sys_rst_n = 1'b1;
    wait_clk(3);

    // READ with ack after 3 cycles
    ack_en = 1'b1; ack_delay = 3; rdata = 16'hBEEF;
    scan(vec(16'h0000, 24'h000123, 2'b01), dummy);
    push_bus(1'b0, 24'h000123, 16'h0000);
    push_scan(vec(16'hBEEF, 24'h000123, 2'b01), all1);
    starts0 = bus_starts;
    pulse_update();
    wait_clk(40);
    check("read_starts", 64'(bus_starts - starts0), 64'd1);
    readback("read_scan");

    // WRITE with immediate ack: exactly one strobe cycle
    ack_delay = 0; stb_cycles = 0;
    scan(vec(16'h55AA, 24'h00FFFF, 2'b10), dummy);
    push_bus(1'b1, 24'h00FFFF, 16'h55AA);
    push_scan(vec(16'h55AA, 24'h00FFFF, 2'b01), all1);
    pulse_update();
    wait_clk(30);
    check("write_stb_cycles", 64'(stb_cycles), 64'd1);
    readback("write_scan");

    // DETECT: no bus cycle
    starts0 = bus_starts;
    scan(vec(16'h1234, 24'hABCDEF, 2'b11), dummy);
    push_scan(vec(16'h0001, 24'hABCDEF, 2'b01), all1);
    pulse_update();
    wait_clk(30);
    check("detect_no_bus", 64'(bus_starts - starts0), 64'd0);
    readback("detect_scan");

    // READ timeout: strobe held for TIMEOUT cycles, status shows err
    ack_en = 1'b0; stb_cycles = 0;
    scan(vec(16'h0000, 24'h000042, 2'b01), dummy);
    push_bus(1'b0, 24'h000042, 16'h0000);
    push_scan(vec(16'h0000, 24'h000042, 2'b11), no_data);
    pulse_update();
    wait_clk(300);
    check("timeout_stb_cycles", 64'(stb_cycles), 64'd255);
    check("timeout_stb_low", 64'(flash_stb), 64'd0);
    readback("timeout_scan");

    // NOP: nothing happens, shifted value stays in sr
    starts0 = bus_starts;
    scan(vec(16'hA5A5, 24'h123456, 2'b00), dummy);
    push_scan(vec(16'hA5A5, 24'h123456, 2'b00), all1);
    pulse_update();
    wait_clk(30);
    check("nop_no_bus", 64'(bus_starts - starts0), 64'd0);
    readback("nop_scan");

    // Second update during ACCESS is ignored; err cleared from the timeout
    ack_en = 1'b1; ack_delay = 20; rdata = 16'h1357;
    starts0 = bus_starts;
    scan(vec(16'h0000, 24'h000077, 2'b01), dummy);
    push_bus(1'b0, 24'h000077, 16'h0000);
    push_scan(vec(16'h1357, 24'h000077, 2'b01), all1);
    pulse_update();
    pulse_update();
    wait_clk(80);
    check("dbl_update_starts", 64'(bus_starts - starts0), 64'd1);
    readback("dbl_update_scan");

    // TAP reset mid-ACCESS: access completes, sr cleared, no DONE load
    starts0 = bus_starts;
    scan(vec(16'hFFFF, 24'h000099, 2'b01), dummy);
    push_bus(1'b0, 24'h000099, 16'hFFFF);
    push_scan('0, all1);
    pulse_update();
    jtag_rst = 1'b1;
    wait_clk(60);
    check("jrst_starts", 64'(bus_starts - starts0), 64'd1);
    check("jrst_stb_low", 64'(flash_stb), 64'd0);
    jtag_rst = 1'b0;
    wait_clk(8);
    readback("jrst_scan");

    // System reset mid-ACCESS drops the strobe asynchronously
    ack_en = 1'b0;
    scan(vec(16'h0000, 24'h000005, 2'b01), dummy);
    push_bus(1'b0, 24'h000005, 16'h0000);
    pulse_update();
    wait_clk(10);
    check("srst_stb_before", 64'(flash_stb), 64'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("srst_stb_async", 64'(flash_stb), 64'd0);
    wait_clk(3);
    sys_rst_n = 1'b1;
    wait_clk(4);
    check("srst_state", 64'(dut.state), 64'(IDLE));
    check("srst_tdo", 64'(jtag_tdo), 64'd0);

    // Still functional after reset
    scan(vec(16'h0000, 24'h000010, 2'b11), dummy);
    push_scan(vec(16'h0001, 24'h000010, 2'b01), all1);
    pulse_update();
    wait_clk(30);
    readback("post_rst_detect");

    check("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
    check("scan_queue_drained", 64'(exp_scan.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
